scroll_scheduler: RTL and testbench
===================================

Name: scroll_scheduler

Overview:
- Frame-synchronous sequencer for the playfield renderer.
- Owns the game run/stop state and produces `status` plus the scroll offsets consumed by the background and pipe drawers.
- All offsets update once per frame at the frame-start strobe, so a frame never tears mid-scan.
- Sits between the input/collision logic and the drawing modules.

Parameters:
STEP_DIV, 4, frames per grass-offset step (1..15)
GRASS_PERIOD, 16, grass pattern period in pixels; grass_pos wraps modulo this value
WORLD_W, 640, scroll_x wraps modulo this value
SPEED, 2, pixels added to scroll_x per running frame (1..15)
DEATH_FRAMES, 60, frames spent in DYING before OVER (1..255)

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-clk pulse at start of vertical blank
flap  in  1  level button input, synchronous to clk
collide  in  1  one-clk pulse from collision detector
status  out  1  1 while state==RUN (scroll enable to drawers)
state  out  2  0 IDLE, 1 RUN, 2 DYING, 3 OVER
grass_pos  out  5  grass pattern offset, 0..GRASS_PERIOD-1
scroll_x  out  10  world scroll offset, 0..WORLD_W-1
frame_cnt  out  8  free-running frame counter, wraps 255->0

Behaviour:
- Reset (async assert, sync release): state=IDLE, status=0, grass_pos=0, scroll_x=0, frame_cnt=0. Internal step divider, death counter, event latches and flap history are all cleared.
- Flap edge:
  - flap_q register; flap_rise = flap & ~flap_q.
  - Only rises are events; a held button generates one event.
- Event latching:
  - flap_rise and collide set sticky latches flap_ev and hit_ev.
  - Latches clear on the clk where frame_start=1.
  - An event arriving on that same clk is consumed in that frame, not carried forward.
- Per-frame update: all actions below occur on the clk where frame_start=1. Outputs are registered and visible the following clk (latency 1). Between strobes all outputs hold.
- frame_cnt: increments every frame in every state.
- FSM, transitions evaluated at frame_start:
  - IDLE: flap_ev -> RUN. Entering RUN clears the step divider; grass_pos and scroll_x are not reset.
  - RUN: hit_ev -> DYING, load death counter with DEATH_FRAMES-1. If flap_ev and hit_ev occur in the same frame, hit wins.
  - DYING: death counter decrements each frame. At 0 -> OVER. Flap ignored; discarded.
  - OVER: flap_ev -> IDLE. On that transition grass_pos=0 and scroll_x=0.
  - collide is ignored outside RUN.
- Scrolling, only in the RUN state-of-record at the strobe, including the frame in which RUN is exited to DYING:
  - scroll_x <= (scroll_x + SPEED) mod WORLD_W. Use an 11-bit sum, then subtract WORLD_W if >= WORLD_W.
  - Step divider counts 0..STEP_DIV-1. On reaching STEP_DIV-1 it resets to 0 and grass_pos increments. grass_pos at GRASS_PERIOD-1 wraps to 0.
  - The divider holds (does not reset) outside RUN.
- Outputs: status = (state==RUN), registered together with state. status and state never disagree on any clk.
- Reset mid-frame: everything returns to reset values immediately. Pending events are lost; the first frame_start after release behaves as from power-up.
- frame_start asserted on consecutive clks is treated as two frames (no gating).

Test Plan:
- Reset then 10 frame_start with no flap -> state=0, status=0, grass_pos=0, scroll_x=0, frame_cnt=10.
- flap pulse, then 9 frames (defaults) -> RUN from first strobe. After 9 running updates scroll_x=18, grass_pos=2 (steps at 4th and 8th updates). status=1 one clk after first strobe.
- In RUN with scroll_x=638, SPEED=2 -> next frame scroll_x=0. With grass_pos=15 at step boundary -> 0.
- collide and flap rise both mid-frame in RUN -> next strobe state=DYING, status=0. Exactly 60 strobes later state=OVER; flap during DYING has no effect.
- flap held high from IDLE through OVER -> only one transition (IDLE->RUN). Release then press in OVER -> IDLE with grass_pos=0, scroll_x=0.
- rst_n low for 3 clks mid-RUN with pending hit_ev -> all outputs 0 immediately. No DYING occurs after release.

Source files
------------

// File: rtl/scroll_scheduler.sv
// -----------------------------------------------------------------------------
// scroll_scheduler
// Frame-synchronous sequencer for the playfield renderer. Owns the game
// run/stop state and the scroll offsets used by the background and pipe
// drawers. Every output changes only on the clk where frame_start=1, so a
// frame never tears mid-scan.
//
// Ports
//   clk          in   pixel/system clock
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-clk pulse at start of vertical blank
//   flap         in   level button, synchronous to clk
//   collide      in   one-clk pulse from the collision detector
//   status       out  1 while state==RUN (scroll enable)
//   state        out  0 IDLE, 1 RUN, 2 DYING, 3 OVER
//   grass_pos    out  grass pattern offset, 0..GRASS_PERIOD-1
//   scroll_x     out  world scroll offset, 0..WORLD_W-1
//   frame_cnt    out  free-running frame counter
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a flap to start a game
// RUN     | game running, offsets scroll every frame
// DYING   | hit taken, counting DEATH_FRAMES frames
// OVER    | game over, flap returns to IDLE and clears offsets
// -----------------------------------------------------------------------------
module scroll_scheduler #(
    parameter int STEP_DIV     = 4,
    parameter int GRASS_PERIOD = 16,
    parameter int WORLD_W      = 640,
    parameter int SPEED        = 2,
    parameter int DEATH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       flap,
    input  logic       collide,
    output logic       status,
    output logic [1:0] state,
    output logic [4:0] grass_pos,
    output logic [9:0] scroll_x,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      st_q, st_d;
    logic        status_q;
    logic [3:0]  div_q, div_d;
    logic [4:0]  grass_q, grass_d;
    logic [9:0]  scroll_q, scroll_d;
    logic [7:0]  frame_q;
    logic [7:0]  dcnt_q, dcnt_d;
    logic        flap_q;
    logic        flap_ev, hit_ev;

    logic        flap_rise;
    logic        flap_now, hit_now;
    logic [10:0] scroll_sum;
    logic [10:0] scroll_wrap;

    assign flap_rise = flap & ~flap_q;

    // An event arriving on the strobe clk itself is consumed by this frame.
    assign flap_now = flap_ev | flap_rise;
    assign hit_now  = hit_ev | collide;

    assign scroll_sum  = {1'b0, scroll_q} + 11'(SPEED);
    assign scroll_wrap = (scroll_sum >= 11'(WORLD_W)) ? (scroll_sum - 11'(WORLD_W)) : scroll_sum;

    always_comb begin
        st_d     = st_q;
        div_d    = div_q;
        grass_d  = grass_q;
        scroll_d = scroll_q;
        dcnt_d   = dcnt_q;
        if (frame_start) begin
            case (st_q)
                S_IDLE: begin
                    if (flap_now) begin
                        st_d  = S_RUN;
                        div_d = 4'd0;
                    end
                end
                S_RUN: begin
                    // Scrolling still happens on the frame that exits to DYING.
                    scroll_d = scroll_wrap[9:0];
                    if (div_q == 4'(STEP_DIV - 1)) begin
                        div_d   = 4'd0;
                        grass_d = (grass_q == 5'(GRASS_PERIOD - 1)) ? 5'd0 : grass_q + 5'd1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                    if (hit_now) begin
                        st_d   = S_DYING;
                        dcnt_d = 8'(DEATH_FRAMES - 1);
                    end
                end
                S_DYING: begin
                    if (dcnt_q == 8'd0) begin
                        st_d = S_OVER;
                    end else begin
                        dcnt_d = dcnt_q - 8'd1;
                    end
                end
                S_OVER: begin
                    if (flap_now) begin
                        st_d     = S_IDLE;
                        grass_d  = 5'd0;
                        scroll_d = 10'd0;
                    end
                end
                default: st_d = st_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            status_q <= 1'b0;
            div_q    <= 4'd0;
            grass_q  <= 5'd0;
            scroll_q <= 10'd0;
            frame_q  <= 8'd0;
            dcnt_q   <= 8'd0;
            flap_q   <= 1'b0;
            flap_ev  <= 1'b0;
            hit_ev   <= 1'b0;
        end else begin
            flap_q <= flap;
            if (frame_start) begin
                st_q     <= st_d;
                status_q <= (st_d == S_RUN);
                div_q    <= div_d;
                grass_q  <= grass_d;
                scroll_q <= scroll_d;
                dcnt_q   <= dcnt_d;
                frame_q  <= frame_q + 8'd1;
                flap_ev  <= 1'b0;
                hit_ev   <= 1'b0;
            end else begin
                if (flap_rise) flap_ev <= 1'b1;
                if (collide)   hit_ev  <= 1'b1;
            end
        end
    end

    assign state     = st_q;
    assign status    = status_q;
    assign grass_pos = grass_q;
    assign scroll_x  = scroll_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
module tb_scroll_scheduler;

    localparam int STEP_DIV     = 4;
    localparam int GRASS_PERIOD = 16;
    localparam int WORLD_W      = 640;
    localparam int SPEED        = 2;
    localparam int DEATH_FRAMES = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       flap = 1'b0;
    logic       collide = 1'b0;
    logic       status;
    logic [1:0] state;
    logic [4:0] grass_pos;
    logic [9:0] scroll_x;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: game-level quantities as plain integers.
    int m_state, m_grass, m_scroll, m_frame;
    int m_runs, m_grass0, m_dying;
    bit m_fev, m_hev, m_flapq;

    scroll_scheduler #(
        .STEP_DIV(STEP_DIV), .GRASS_PERIOD(GRASS_PERIOD), .WORLD_W(WORLD_W),
        .SPEED(SPEED), .DEATH_FRAMES(DEATH_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .flap(flap),
        .collide(collide), .status(status), .state(state),
        .grass_pos(grass_pos), .scroll_x(scroll_x), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_grass = 0; m_scroll = 0; m_frame = 0;
        m_runs = 0; m_grass0 = 0; m_dying = 0;
        m_fev = 0; m_hev = 0; m_flapq = 0;
    endtask

    // One clock of the game rules, using the inputs the DUT just sampled.
    task automatic model_clock(input bit fs, input bit fl, input bit co);
        bit rise, fe, he;
        rise = fl && !m_flapq;
        m_flapq = fl;
        if (!fs) begin
            m_fev = m_fev | rise;
            m_hev = m_hev | co;
            return;
        end
        fe = m_fev | rise;
        he = m_hev | co;
        m_fev = 0;
        m_hev = 0;
        m_frame = (m_frame + 1) % 256;
        case (m_state)
            0: if (fe) begin m_state = 1; m_runs = 0; m_grass0 = m_grass; end
            1: begin
                m_runs++;
                m_scroll = (m_scroll + SPEED) % WORLD_W;
                m_grass  = (m_grass0 + m_runs / STEP_DIV) % GRASS_PERIOD;
                if (he) begin m_state = 2; m_dying = 0; end
            end
            2: begin
                m_dying++;
                if (m_dying == DEATH_FRAMES) m_state = 3;
            end
            default: if (fe) begin m_state = 0; m_grass = 0; m_scroll = 0; end
        endcase
    endtask

    task automatic check_all();
        chk("state",     int'(state),     m_state);
        chk("status",    int'(status),    (m_state == 1) ? 1 : 0);
        chk("grass_pos", int'(grass_pos), m_grass);
        chk("scroll_x",  int'(scroll_x),  m_scroll);
        chk("frame_cnt", int'(frame_cnt), m_frame);
    endtask

    task automatic cyc(input bit fs, input bit fl, input bit co);
        frame_start = fs; flap = fl; collide = co;
        @(posedge clk);
        if (rst_n) model_clock(fs, fl, co);
        #1;
        check_all();
    endtask

    task automatic strobe(input bit fl);
        cyc(1'b1, fl, 1'b0);
        cyc(1'b0, fl, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (n) cyc(1'b0, flap, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit fs, co;
        bit fl;
        #2;
        do_reset(2);

        // No flap: stays IDLE, only frame_cnt moves.
        repeat (10) strobe(1'b0);
        chk("t1_state", int'(state), 0);
        chk("t1_status", int'(status), 0);
        chk("t1_scroll", int'(scroll_x), 0);
        chk("t1_frame", int'(frame_cnt), 10);

        // Start a game; first strobe enters RUN, later strobes scroll.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("t2_state_run", int'(state), 1);
        chk("t2_status_run", int'(status), 1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (8) strobe(1'b0);
        chk("t2_scroll_8", int'(scroll_x), 16);
        chk("t2_grass_8", int'(grass_pos), 2);

        // 319 running updates -> scroll 638, grass 15, divider at boundary.
        repeat (311) strobe(1'b0);
        chk("t3_scroll_638", int'(scroll_x), 638);
        chk("t3_grass_15", int'(grass_pos), 15);
        strobe(1'b0);
        chk("t3_scroll_wrap", int'(scroll_x), 0);
        chk("t3_grass_wrap", int'(grass_pos), 0);

        // Hit and flap in the same frame: hit wins.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        chk("t4_dying", int'(state), 2);
        chk("t4_status", int'(status), 0);
        repeat (DEATH_FRAMES - 1) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            strobe(1'b0);
        end
        chk("t4_still_dying", int'(state), 2);
        strobe(1'b0);
        chk("t4_over", int'(state), 3);

        // OVER -> IDLE clears offsets.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        chk("t5_idle", int'(state), 0);
        chk("t5_scroll0", int'(scroll_x), 0);

        // Held flap gives exactly one event.
        cyc(1'b0, 1'b1, 1'b0);
        strobe(1'b1);
        chk("t5_held_run", int'(state), 1);
        cyc(1'b0, 1'b1, 1'b1);
        strobe(1'b1);
        repeat (DEATH_FRAMES + 5) strobe(1'b1);
        chk("t5_held_over", int'(state), 3);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        chk("t5_rel_idle", int'(state), 0);
        chk("t5_rel_grass0", int'(grass_pos), 0);
        chk("t5_rel_scroll0", int'(scroll_x), 0);

        // Reset mid-RUN with a pending hit: hit is lost.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (4) strobe(1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        do_reset(3);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_frame", int'(frame_cnt), 0);
        strobe(1'b0);
        chk("t6_no_dying", int'(state), 0);
        chk("t6_frame1", int'(frame_cnt), 1);

        // Random traffic against the model.
        fl = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                fs = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0) fl = ~fl;
                co = ($urandom_range(0, 23) == 0);
                cyc(fs, fl, co);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
